// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch unit <-> instruction memory / decode signal bundle
interface instruction_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] mem_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  modport master (
    input  fetch_en, mem_instr, redirect_valid, redirect_pc, out_ready,
    output pc, out_valid, out_instr, out_pc
  );
  modport slave (
    output fetch_en, mem_instr, redirect_valid, redirect_pc, out_ready,
    input  pc, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing, one-deep read tracking and instruction buffer with redirect flush
module instruction_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  instruction_fetch_if.master bus
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   CAP  = (CW + 1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [DATA_W-1:0] instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_q  [FIFO_DEPTH];
  logic              valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       occ;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  // handshake decode; the issue check counts the in-flight word and credits a same-cycle pop
  always_comb begin
    valid = count_q != '0;
    pop   = valid & bus.out_ready;
    push  = inflight_q & ~bus.redirect_valid;
    occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue = (state_q == RUN) & bus.fetch_en & ~bus.redirect_valid & (occ < CAP);
  end
  assign bus.pc        = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? instr_q[rd_q] : '0;
  assign bus.out_pc    = valid ? addr_q[rd_q] : '0;
  // fetch FSM, PC, in-flight tracking and FIFO pointers; redirect flushes everything buffered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      assert (!(push && !pop && count_q == CW'(FIFO_DEPTH)));
      state_q    <= bus.fetch_en ? RUN : IDLE;
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + 1'b1;
        req_pc_q <= pc_q;
      end
      if (bus.redirect_valid) begin
        pc_q    <= bus.redirect_pc;
        count_q <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
      end else begin
        if (push) wr_q <= nxt(wr_q);
        if (pop) rd_q <= nxt(rd_q);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end
  // buffer storage; contents are only visible while count is non-zero so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_q] <= bus.mem_instr;
      addr_q[wr_q]  <= req_pc_q;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random checks of the fetch stream against an address-sequence model
module tb_instruction_fetch;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  instruction_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_cmp = 0;
  int n_err = 0;
  int pops = 0;
  logic [AW-1:0] exp_pc = '0;
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + DW'(a);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    logic [AW-1:0] pc_s;
    logic [AW-1:0] hpc;
    logic [DW-1:0] hin;
    logic [AW-1:0] lead;
    logic hold;
    pc_s = bus.pc;
    hpc  = bus.out_pc;
    hin  = bus.out_instr;
    hold = bus.out_valid && !bus.out_ready && reset && !bus.redirect_valid;
    if (bus.out_valid && bus.out_ready) begin
      chk("pop_pc", 32'(bus.out_pc), 32'(exp_pc));
      chk("pop_instr", bus.out_instr, mem_word(exp_pc));
      exp_pc = bus.out_pc + 1'b1;
      pops++;
    end
    if (bus.redirect_valid) exp_pc = bus.redirect_pc;
    if (!reset) exp_pc = '0;
    @(posedge clk);
    #1;
    bus.mem_instr = mem_word(pc_s);
    if (hold) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_pc", 32'(bus.out_pc), 32'(hpc));
      chk("hold_instr", bus.out_instr, hin);
    end
    if (bus.out_valid) begin
      lead = bus.pc - bus.out_pc;
      chk("pc_lead", 32'(lead <= AW'(DEPTH)), 32'd1);
    end
  endtask
  initial begin
    logic [AW-1:0] pc_s;
    int p0;
    bus.fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_instr = '0;
    repeat (3) cycle();
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
    reset = 1'b1;
    cycle();
    chk("start_e1_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("start_e2_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("start_e3_valid", 32'(bus.out_valid), 32'd1);
    chk("start_out_pc", 32'(bus.out_pc), 32'd0);
    chk("start_instr", bus.out_instr, mem_word(16'd0));
    p0 = pops;
    repeat (10) begin
      cycle();
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
    end
    chk("stream_pops", 32'(pops - p0), 32'd10);
    chk("stream_next_pc", 32'(bus.out_pc), 32'd10);
    bus.out_ready = 1'b0;
    repeat (5) cycle();
    chk("bp_pc", 32'(bus.pc), 32'd12);
    bus.out_ready = 1'b1;
    repeat (5) begin
      cycle();
      chk("resume_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b0;
    cycle();
    chk("pre_redir_full", 32'(bus.out_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0020;
    cycle();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("redir_e0_valid", 32'(bus.out_valid), 32'd0);
    chk("redir_e0_pc", 32'(bus.pc), 32'h20);
    cycle();
    chk("redir_e1_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("redir_e2_valid", 32'(bus.out_valid), 32'd1);
    chk("redir_out_pc", 32'(bus.out_pc), 32'h20);
    chk("redir_instr", bus.out_instr, mem_word(16'h0020));
    repeat (3) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    cycle();
    bus.redirect_valid = 1'b0;
    p0 = pops;
    repeat (7) cycle();
    chk("wrap_pops", 32'(pops - p0), 32'd5);
    chk("wrap_exp_pc", 32'(exp_pc), 32'd3);
    bus.fetch_en = 1'b0;
    repeat (4) cycle();
    chk("fen_off_valid", 32'(bus.out_valid), 32'd0);
    chk("fen_off_pc", 32'(bus.pc), 32'(exp_pc));
    pc_s = bus.pc;
    repeat (3) cycle();
    chk("fen_off_hold_pc", 32'(bus.pc), 32'(pc_s));
    bus.fetch_en = 1'b1;
    repeat (6) cycle();
    bus.fetch_en = 1'b0;
    repeat (4) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0100;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("idle_redir_pc", 32'(bus.pc), 32'h100);
    chk("idle_redir_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("idle_stay_pc", 32'(bus.pc), 32'h100);
    bus.fetch_en = 1'b1;
    p0 = pops;
    repeat (6) cycle();
    chk("idle_resume_pops", 32'(pops - p0), 32'd3);
    bus.out_ready = 1'b0;
    repeat (3) cycle();
    chk("mid_full_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_pc", 32'(bus.pc), 32'd0);
    p0 = pops;
    repeat (600) begin
      bus.out_ready = $urandom_range(0, 9) < 7;
      bus.fetch_en = $urandom_range(0, 9) != 0;
      bus.redirect_valid = $urandom_range(0, 19) == 0;
      bus.redirect_pc = 16'($urandom);
      reset = $urandom_range(0, 99) != 0;
      cycle();
    end
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    chk("rand_progress", 32'(pops - p0 > 150), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch front end that drives the word address into the instruction memory and turns its fixed one-cycle registered read into a valid/ready instruction stream for decode. It holds the fetch PC, tracks the single in-flight read, buffers returned words in a small FIFO so decode back-pressure never loses data, and handles branch/jump redirects by flushing stale words.

## Interface
- ADDR_W, 16: width of fetch PC / memory word address.
- DATA_W, 32: instruction width.
- RESET_PC, 0: fetch address loaded on reset.
- FIFO_DEPTH, 2: instruction buffer entries (≥2; 2 gives 1 instr/cycle).
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low (0 = reset).
- fetch_en  input  1  1 = allowed to issue new reads.
- pc  output  ADDR_W  word address to instruction memory (registered fetch PC).
- mem_instr  input  DATA_W  memory read data; holds word for the pc sampled at the previous edge.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_pc  input  ADDR_W  redirect target.
- out_valid  output  1  out_instr/out_pc valid.
- out_ready  input  1  decode accepts this cycle.
- out_instr  output  DATA_W  instruction at FIFO head.
- out_pc  output  ADDR_W  address of out_instr.

## Operation
- States: IDLE (no issue), RUN (issuing). Reset -> IDLE. IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0. In-flight read always completes into FIFO regardless of state.
- pop = out_valid & out_ready. issue = RUN & fetch_en & ~redirect_valid & (count + inflight − pop < FIFO_DEPTH).
- On issue at edge: memory samples pc; pc <= pc+1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000); inflight <= 1; req_pc <= pc. Without issue: pc holds, inflight <= 0.
- If inflight=1 at an edge (and no redirect): push {mem_instr, req_pc} to FIFO.
- Push and pop in same cycle allowed at any occupancy; count unchanged.
- FIFO never overflows by construction; assertion: push with count=FIFO_DEPTH and no pop is an error.
- redirect_valid=1: FIFO cleared (count=0), inflight <= 0 (returning word discarded), pc <= redirect_pc, no issue that cycle. A pop in the same cycle counts as consumed by decode; the flush still happens. Redirect has priority over fetch_en and all pushes.
- Redirect in IDLE: pc updated, FIFO flushed, stays IDLE.
- out_valid = (count≠0); out_instr/out_pc = FIFO head, stable while out_valid & ~out_ready.

## Timing
- Reset (reset=0 at edge): pc=RESET_PC, state IDLE, count=0, inflight=0, out_valid=0, out_instr=0, out_pc=0. Reset mid-operation discards FIFO and in-flight word.
- Read latency: issue at edge N -> pushed at edge N+1 -> out_valid high after N+1 (if FIFO was empty).
- From reset release with fetch_en=1: edge 1 IDLE->RUN, edge 2 issue RESET_PC, edge 3 push, out_valid=1 after edge 3.
- Redirect at edge E: issue redirect_pc at E+1, out_valid for target after E+2 (2 bubble cycles).
- Steady state, out_ready=1: one instruction per cycle, consecutive out_pc.
- out_ready=0: at most FIFO_DEPTH words buffered; issue stops; resumes the edge ready returns (issue condition uses same-cycle pop).

## Test plan
- Reset: hold reset=0 3 cycles with fetch_en=1 -> pc=0, out_valid=0; release -> out_valid rises after 3rd edge, out_pc=0, out_instr=mem[0].
- Streaming: memory preloaded mem[i]=0x1000_0000+i, out_ready=1 -> out_pc 0,1,2,...,9 on consecutive cycles, out_instr matches, no gaps.
- Back-pressure: drop out_ready for 5 cycles mid-stream -> out_instr held stable, pc advances at most FIFO_DEPTH beyond head, no word lost or duplicated on resume.
- Redirect: redirect_valid with redirect_pc=0x0020 while FIFO full and read in flight -> next out_valid word has out_pc=0x0020 after 2 bubbles; no pre-redirect word appears.
- Wrap: redirect_pc=0xFFFE -> out_pc 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- fetch_en toggle / reset mid-run: fetch_en=0 -> in-flight word still delivered, then no new issue; reset=0 with 2 words buffered -> out_valid=0 next cycle, pc=RESET_PC.
